// File: rtl/axis_i2s2_follower.sv
// -----------------------------------------------------------------------------
// axis_i2s2_follower
//
// Codec-side I2S endpoint. The bit clock and word select are driven by an
// external controller. They are synchronised into axis_clk, and all framing is
// done on the synchronised sclk rising edge. Received left/right samples are
// presented as a two-beat AXI-Stream frame (L with last=0, then R with last=1).
// One buffered AXI-Stream L/R frame is serialised back onto sdout.
//
// Ports:
//   axis_clk, axis_resetn    system clock (>= 8x sclk), async active-low reset
//   i2s_sclk, i2s_lrck       bit clock and word select (0 = left, 1 = right)
//   i2s_sdin / i2s_sdout     serial data from / to the controller, MSB first
//   rx_axis_m_*              received stereo frame, last marks the right beat
//   tx_axis_s_*              frame to transmit, last=0 left beat, last=1 right
//   overrun                  sticky: a received frame was dropped
//   underrun                 sticky: a left/right slot pair went out with no frame
// -----------------------------------------------------------------------------
module axis_i2s2_follower #(
   parameter int unsigned DATA_WIDTH  = 24,
   parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
   input  logic                  axis_clk,
   input  logic                  axis_resetn,
   input  logic                  i2s_sclk,
   input  logic                  i2s_lrck,
   input  logic                  i2s_sdin,
   output logic                  i2s_sdout,
   output logic [DATA_WIDTH-1:0] rx_axis_m_data,
   output logic                  rx_axis_m_valid,
   input  logic                  rx_axis_m_ready,
   output logic                  rx_axis_m_last,
   input  logic [DATA_WIDTH-1:0] tx_axis_s_data,
   input  logic                  tx_axis_s_valid,
   output logic                  tx_axis_s_ready,
   input  logic                  tx_axis_s_last,
   output logic                  overrun,
   output logic                  underrun
);

   localparam int unsigned CntW = $clog2(DATA_WIDTH + 2);
   localparam logic [CntW-1:0] CntWord = CntW'(DATA_WIDTH);
   localparam logic [CntW-1:0] CntMax  = CntW'(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      RxIdle,
      RxLeft,
      RxRight
   } rx_state_e;

   // ---------------------------------------------------------------------------
   // Input synchronisers
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] lrck_sync_q;
   logic [SYNC_STAGES-1:0] sdin_sync_q;
   logic                   sclk_s;
   logic                   lrck_s;
   logic                   sdin_s;

   always_ff @(posedge axis_clk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         sclk_sync_q <= '0;
         lrck_sync_q <= '0;
         sdin_sync_q <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i2s_sclk};
         lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], i2s_lrck};
         sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], i2s_sdin};
      end
   end

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
   assign sdin_s = sdin_sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------------------
   // Slot framing
   // ---------------------------------------------------------------------------
   logic                  sclk_prev_q;
   logic                  ch_q;          // lrck seen at the previous rise = current channel
   logic [CntW-1:0]       bit_cnt_q;
   logic [CntW-1:0]       cnt_next;
   logic [DATA_WIDTH-1:0] rx_shift_q;
   logic [DATA_WIDTH-1:0] word_in;
   logic [DATA_WIDTH-1:0] left_word_q;
   logic                  left_armed_q;  // a 1->0 channel start has been seen since reset
   logic                  left_valid_q;  // left word of the current frame is held
   logic                  rise;
   logic                  ch_start;
   logic                  start_left;
   logic                  start_right;
   logic                  bit_in;
   logic                  word_done;
   logic                  left_done;
   logic                  frame_done;

   always_comb begin
      rise        = sclk_s & ~sclk_prev_q;
      ch_start    = rise & (lrck_s != ch_q);
      start_left  = ch_start & ~lrck_s;
      start_right = ch_start & lrck_s;

      cnt_next = bit_cnt_q;
      if (ch_start) begin
         cnt_next = '0;
      end else if (rise && bit_cnt_q != CntMax) begin
         cnt_next = bit_cnt_q + CntW'(1);
      end

      bit_in     = rise & ~ch_start & (cnt_next != '0) & (cnt_next <= CntWord);
      word_done  = bit_in & (cnt_next == CntWord);
      word_in    = {rx_shift_q[DATA_WIDTH-2:0], sdin_s};
      // Words before lock, or a right word without its left partner, fall through.
      left_done  = word_done & ~ch_q & left_armed_q;
      frame_done = word_done & ch_q & left_valid_q;
   end

   always_ff @(posedge axis_clk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         sclk_prev_q  <= 1'b0;
         ch_q         <= 1'b0;
         bit_cnt_q    <= '0;
         rx_shift_q   <= '0;
         left_word_q  <= '0;
         left_armed_q <= 1'b0;
         left_valid_q <= 1'b0;
      end else begin
         sclk_prev_q <= sclk_s;
         bit_cnt_q   <= cnt_next;
         if (rise) begin
            ch_q <= lrck_s;
         end
         if (bit_in) begin
            rx_shift_q <= word_in;
         end
         if (start_left) begin
            left_armed_q <= 1'b1;
            left_valid_q <= 1'b0;
         end else if (left_done) begin
            left_word_q  <= word_in;
            left_valid_q <= 1'b1;
         end else if (frame_done) begin
            left_valid_q <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // RX stream output
   // ---------------------------------------------------------------------------
   rx_state_e             rx_state_q;
   rx_state_e             rx_state_d;
   logic [DATA_WIDTH-1:0] frame_l_q;
   logic [DATA_WIDTH-1:0] frame_r_q;
   logic                  frame_load;
   logic                  overrun_q;
   logic                  overrun_d;

   always_comb begin
      rx_state_d = rx_state_q;
      frame_load = 1'b0;
      overrun_d  = overrun_q;
      unique case (rx_state_q)
         RxIdle: begin
            if (frame_done) begin
               rx_state_d = RxLeft;
               frame_load = 1'b1;
            end
         end
         RxLeft: begin
            if (rx_axis_m_ready) begin
               rx_state_d = RxRight;
            end
            // The right beat is still owed, so a new frame cannot be taken.
            if (frame_done) begin
               overrun_d = 1'b1;
            end
         end
         RxRight: begin
            if (rx_axis_m_ready) begin
               rx_state_d = RxIdle;
               // Last beat leaves on this edge, so a completing frame fits.
               if (frame_done) begin
                  rx_state_d = RxLeft;
                  frame_load = 1'b1;
               end
            end else if (frame_done) begin
               overrun_d = 1'b1;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_ff @(posedge axis_clk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         rx_state_q <= RxIdle;
         frame_l_q  <= '0;
         frame_r_q  <= '0;
         overrun_q  <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         overrun_q  <= overrun_d;
         if (frame_load) begin
            frame_l_q <= left_word_q;
            frame_r_q <= word_in;
         end
      end
   end

   assign rx_axis_m_valid = (rx_state_q != RxIdle);
   assign rx_axis_m_last  = (rx_state_q == RxRight);
   assign rx_axis_m_data  = (rx_state_q == RxRight) ? frame_r_q : frame_l_q;
   assign overrun         = overrun_q;

   // ---------------------------------------------------------------------------
   // TX holding frame and serialiser
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] tx_l_q;
   logic [DATA_WIDTH-1:0] tx_r_q;
   logic                  frame_full_q;
   logic                  frame_full_d;
   logic                  tx_ready_q;
   logic                  tx_accept;
   logic [DATA_WIDTH-1:0] tx_shift_q;
   logic [DATA_WIDTH-1:0] tx_shift_d;
   logic [DATA_WIDTH-1:0] tx_stage_q;
   logic [DATA_WIDTH-1:0] tx_stage_d;
   logic                  sdout_q;
   logic                  sdout_d;
   logic                  underrun_q;
   logic                  underrun_d;

   assign tx_accept = tx_axis_s_valid & tx_ready_q;

   always_comb begin
      frame_full_d = frame_full_q;
      if (start_left && frame_full_q) begin
         frame_full_d = 1'b0;
      end
      if (tx_accept && tx_axis_s_last) begin
         frame_full_d = 1'b1;
      end
   end

   always_comb begin
      tx_shift_d = tx_shift_q;
      tx_stage_d = tx_stage_q;
      sdout_d    = sdout_q;
      underrun_d = underrun_q;
      if (start_left) begin
         if (frame_full_q) begin
            tx_shift_d = tx_l_q;
            tx_stage_d = tx_r_q;
         end else begin
            tx_shift_d = '0;
            tx_stage_d = '0;
            underrun_d = 1'b1;
         end
         sdout_d = tx_shift_d[DATA_WIDTH-1];
      end else if (start_right) begin
         tx_shift_d = tx_stage_q;
         sdout_d    = tx_stage_q[DATA_WIDTH-1];
      end else if (rise) begin
         // The MSB went out at the channel start; each later rise presents the
         // next bit so it is stable for the controller's following sample.
         if (cnt_next < CntWord) begin
            sdout_d    = tx_shift_q[DATA_WIDTH-2];
            tx_shift_d = tx_shift_q << 1;
         end else begin
            sdout_d = 1'b0;
         end
      end
   end

   always_ff @(posedge axis_clk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         tx_l_q       <= '0;
         tx_r_q       <= '0;
         frame_full_q <= 1'b0;
         tx_ready_q   <= 1'b0;
         tx_shift_q   <= '0;
         tx_stage_q   <= '0;
         sdout_q      <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         frame_full_q <= frame_full_d;
         tx_ready_q   <= ~frame_full_d;
         tx_shift_q   <= tx_shift_d;
         tx_stage_q   <= tx_stage_d;
         sdout_q      <= sdout_d;
         underrun_q   <= underrun_d;
         if (tx_accept) begin
            if (tx_axis_s_last) begin
               tx_r_q <= tx_axis_s_data;
            end else begin
               tx_l_q <= tx_axis_s_data;
            end
         end
      end
   end

   assign tx_axis_s_ready = tx_ready_q;
   assign i2s_sdout       = sdout_q;
   assign underrun        = underrun_q;

endmodule

// File: doc/axis_i2s2_follower.md
Name: axis_i2s2_follower

Overview:
- I2S follower (codec-side) endpoint: the other end of the I2S link driven by axis_i2s2.
- Takes externally driven sclk and lrck and synchronises them into axis_clk.
- Deserialises sdin into stereo AXIS master frames and serialises AXIS slave frames onto sdout.
- Used as a bit-accurate codec stand-in and as a follower-mode port for a second board or codec.

Parameters:
- DATA_WIDTH, 24, sample width in bits on both AXIS and I2S (MSB first).
- SYNC_STAGES, 2, flops per input synchroniser (minimum 2).

Ports:
- axis_clk  in  1  system clock; must be at least 8x the sclk frequency.
- axis_resetn  in  1  asynchronous, active-low reset.
- i2s_sclk  in  1  bit clock from the I2S controller.
- i2s_lrck  in  1  word select: 0 = left, 1 = right.
- i2s_sdin  in  1  serial data from the controller.
- i2s_sdout  out  1  serial data to the controller.
- rx_axis_m_data  out  DATA_WIDTH  received sample.
- rx_axis_m_valid  out  1  received beat valid.
- rx_axis_m_ready  in  1  downstream ready.
- rx_axis_m_last  out  1  high on the right-channel beat.
- tx_axis_s_data  in  DATA_WIDTH  sample to transmit.
- tx_axis_s_valid  in  1  transmit beat valid.
- tx_axis_s_ready  out  1  high while the tx holding frame is not full.
- tx_axis_s_last  in  1  0 = left beat, 1 = right beat.
- overrun  out  1  sticky: an rx frame was dropped.
- underrun  out  1  sticky: a tx slot was sent without a buffered frame.

Behaviour:
- Reset: all outputs and internal registers go to 0. After reset, tx_axis_s_ready returns to 1 on the first clock edge.
- Sync: sclk, lrck and sdin each pass through SYNC_STAGES flops.
  - A rise event is flagged when synced sclk is 1 and the previous synced sclk was 0.
  - All framing happens only on rise events. There is no falling-edge logic.
- Framing, on each rise event: compare synced lrck with the lrck stored at the previous rise event.
  - If they differ: channel start. bit_cnt <= 0, ch <= lrck. The sdin bit sampled here is the previous slot's delay bit and is ignored.
  - Otherwise, bit_cnt increments, saturating at DATA_WIDTH+1.
  - Samples with 1 <= bit_cnt <= DATA_WIDTH shift sdin in MSB first. When bit_cnt reaches DATA_WIDTH the word is complete.
- Lock:
  - No rx word is captured and no tx word is loaded until the first channel start after reset.
  - The left channel is armed only at a 1->0 lrck channel start, so the first frame after reset is always a full L,R pair.
  - A right word completing without a preceding left word in the same frame is discarded.
- RX path:
  - A completed left word is held in the left register.
  - A completed right word forms the {L,R} frame.
  - If the output is idle, the frame loads: present L with valid=1, last=0. After that handshake present R with last=1. After the R handshake, valid=0.
  - If a beat is still pending when a new frame completes: set overrun, drop the new frame, leave the pending frame untouched.
  - data, last and valid remain stable while valid=1 and ready=0.
- TX input:
  - A beat is accepted when valid and ready are both high.
  - last=0 writes tx_L; last=1 writes tx_R and sets frame_full.
  - ready=0 while frame_full.
  - A second last=0 beat before last=1 overwrites tx_L.
- TX output:
  - At a 1->0 channel start: if frame_full, load shift <= tx_L, stage <= tx_R, and clear frame_full (ready rises on the next clock). Otherwise set underrun and load 0 into both shift and stage.
  - At a 0->1 channel start: load shift <= stage.
  - On the same rise event as the load, sdout is registered to the MSB. On rise events with 1 <= bit_cnt <= DATA_WIDTH-1, sdout takes the next bit. For bit_cnt >= DATA_WIDTH, sdout = 0.
  - sdout therefore changes about 3-4 axis_clk after the sclk rise and is stable across the controller's next rising-edge sample.
- Simultaneous events:
  - An rx handshake and a frame completion in the same cycle: the completion is accepted, with no overrun.
  - A tx accept and frame consumption in the same cycle are not possible, because ready=0 while full.
- Reset mid-frame: partial words are discarded, both sticky flags clear, and lock is re-acquired.

Test Plan:
1. Reset asserted with toggling sclk -> sdout=0, rx valid=0, tx ready=0; ready=1 one clock after deassert; overrun=0, underrun=0.
2. Controller model: sclk = axis_clk/8, 32 sclk per slot, sends L=0x123456, R=0xABCDEF, ready held high -> rx beats 0x123456/last=0 then 0xABCDEF/last=1; exactly one frame per lrck period after lock.
3. rx ready low for 3 frames -> first frame's L beat held stable, overrun=1, frames 2-3 dropped; ready high -> 0x123456 then 0xABCDEF, then frame 4.
4. Push L=0x800001 (last=0), R=0x7FFFFF (last=1) -> controller decodes 0x800001 left and 0x7FFFFF right; bits after DATA_WIDTH are 0; ready low until the next left channel start.
5. No tx frame supplied -> sdout all 0 for the whole frame, underrun=1, ready stays high.
6. Reset pulsed mid-left-word, then released -> no rx beat until a full L,R frame after the next 1->0 lrck edge; partial word never emitted.
